// File: rtl/bt_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bt_tx_scheduler
// Purpose  : round-robin share of one UART TX line among 4 requesters; one
//            byte per 8N1 frame. `define BT_TX_PARITY_EN adds an even parity bit.
// Revision : 1.0  initial release
// ============================================================================
module bt_tx_scheduler #(
  parameter int CLKS_PER_BIT = 13021,
  parameter int NUM_REQ      = 4
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_flat,
  output logic [NUM_REQ-1:0]   ack,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 TX
);

  localparam logic [14:0] C_BIT_LAST = 15'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [14:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
`ifdef BT_TX_PARITY_EN
  logic        r_parity;
`endif

  logic        w_found;
  logic [1:0]  w_grant;
  logic [1:0]  w_idx;
  logic        w_bit_end;

  assign w_bit_end = (r_cnt == C_BIT_LAST);

  // Search starts just after the last winner, so the 2-bit add wraps naturally.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_ptr;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd3;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
`ifdef BT_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
      ack        <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      TX         <= 1'b1;
    end else begin
      ack        <= '0;
      frame_done <= 1'b0;
      if (r_state != S_IDLE)
        r_cnt <= w_bit_end ? '0 : r_cnt + 15'd1;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_shift      <= data_flat[{w_grant, 3'b000} +: 8];
`ifdef BT_TX_PARITY_EN
            r_parity     <= ^data_flat[{w_grant, 3'b000} +: 8];
`endif
            ack[w_grant] <= 1'b1;
            grant_id     <= w_grant;
            r_ptr        <= w_grant;
            busy         <= 1'b1;
            TX           <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            TX      <= r_shift[0];
            r_idx   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_idx == 3'd7) begin
`ifdef BT_TX_PARITY_EN
              TX      <= r_parity;
              r_state <= S_PARITY;
`else
              TX      <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              // Present the next bit while shifting, so TX stays registered.
              r_idx   <= r_idx + 3'd1;
              r_shift <= r_shift >> 1;
              TX      <= r_shift[1];
            end
          end
        end
`ifdef BT_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            TX      <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bt_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bt_tx_scheduler
// Purpose  : vector table plus serial-frame scoreboard for bt_tx_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_bt_tx_scheduler;

  localparam int CPB = 16;
`ifdef BT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        reset_p;
  logic [3:0]  req;
  logic [31:0] data_flat;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        frame_done;
  logic        TX;

  bt_tx_scheduler #(.CLKS_PER_BIT(CPB), .NUM_REQ(4)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .req        (req),
    .data_flat  (data_flat),
    .ack        (ack),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done),
    .TX         (TX)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  g;
    logic [7:0]  b;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         frames = 0;
  bit         in_frame = 0;
  bit         no_check = 0;
  logic [7:0] q[$];
  int         starts[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef BT_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Frame monitor: checks every TX cycle against the byte at the head of the queue.
  initial begin : monitor
    logic          prev_tx;
    int            ph;
    bit            skip;
    logic [NB-1:0] exp_bits;
    prev_tx  = 1'b1;
    ph       = 0;
    skip     = 0;
    exp_bits = '1;
    forever begin
      @(negedge clk);
      #2;
      if (reset_p) begin
        in_frame = 0;
      end else if (!in_frame) begin
        if (prev_tx && !TX) begin
          in_frame = 1;
          ph       = 0;
          skip     = no_check;
          starts.push_back(cyc);
          if (!skip) begin
            chk("frame_expected", (q.size() != 0), 1);
            exp_bits = frame_bits(q.size() != 0 ? q[0] : 8'h00);
          end
        end
      end else begin
        ph++;
      end
      if (in_frame && !skip) begin
        if (ph < NB*CPB) chk("tx_bit", TX, exp_bits[ph/CPB]);
        if (ph == NB*CPB-1) chk("frame_done_early", frame_done, 0);
        if (ph == NB*CPB) begin
          chk("frame_done", frame_done, 1);
          chk("busy_end", busy, 0);
          if (q.size() != 0) void'(q.pop_front());
          frames++;
          in_frame = 0;
        end
      end else if (in_frame && skip && ph == NB*CPB) begin
        frames++;
        in_frame = 0;
      end
      prev_tx = TX;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_grant_id", grant_id, 0);
    reset_p = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(input logic [1:0] g, input logic [7:0] b, input bit push);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0 && n < 400);
    chk("ack", ack, 32'(4'b0001 << g));
    chk("grant_id", grant_id, g);
    chk("busy_grant", busy, 1);
    if (push) q.push_back(b);
  endtask

  task automatic wait_idle(output int acks);
    int n = 0;
    acks = 0;
    do begin
      @(negedge clk);
      n++;
      if (ack != 4'b0) acks++;
    end while ((busy || q.size() != 0 || in_frame) && n < 1000);
    chk("idle_reached", (n < 1000), 1);
  endtask

  initial begin : stim
    vec_t tbl[9];
    int   a;
    int   f0;
    int   fd;
    reset_p   = 1'b1;
    req       = 4'b0;
    data_flat = 32'h0;

    tbl[0] = '{4'b0001, 32'h0000_0030, 2'd0, 8'h30};
    tbl[1] = '{4'b0110, 32'h00C3_5A00, 2'd1, 8'h5A};
    tbl[2] = '{4'b1001, 32'hA500_00FF, 2'd3, 8'hA5};
    tbl[3] = '{4'b1100, 32'h817E_0000, 2'd2, 8'h7E};
    tbl[4] = '{4'b1001, 32'h1200_0034, 2'd3, 8'h12};
    tbl[5] = '{4'b1001, 32'h5600_0078, 2'd0, 8'h78};
    tbl[6] = '{4'b1010, 32'h9A00_BC00, 2'd1, 8'hBC};
    tbl[7] = '{4'b1111, 32'h0180_FEEF, 2'd2, 8'h80};
    tbl[8] = '{4'b0001, 32'h0000_0031, 2'd0, 8'h31};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      req       = tbl[i].req;
      data_flat = tbl[i].data;
      wait_ack(tbl[i].g, tbl[i].b, 1'b1);
      req       = 4'b0;
      data_flat = ~data_flat;
      wait_idle(a);
      chk("spurious_ack", a, 0);
    end

    // All four requesting and held: 0,1,2,3,0 with back-to-back frames.
    do_reset();
    starts.delete();
    data_flat = 32'h4443_4241;
    req       = 4'b1111;
    wait_ack(2'd0, 8'h41, 1'b1);
    wait_ack(2'd1, 8'h42, 1'b1);
    wait_ack(2'd2, 8'h43, 1'b1);
    wait_ack(2'd3, 8'h44, 1'b1);
    wait_ack(2'd0, 8'h41, 1'b1);
    req = 4'b0;
    wait_idle(a);
    chk("rr_frames", starts.size(), 5);
    for (int i = 0; i < 4 && i + 1 < starts.size(); i++)
      chk("start_gap", starts[i+1] - starts[i], NB*CPB + 1);

    // Reset 50 cycles into a frame from requester 1; pointer must return to 3.
    no_check  = 1;
    data_flat = 32'h0000_5C00;
    req       = 4'b0010;
    wait_ack(2'd1, 8'h5C, 1'b0);
    req = 4'b0;
    repeat (50) @(negedge clk);
    f0      = frames;
    reset_p = 1'b1;
    #1;
    chk("abort_tx", TX, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack, 0);
    @(negedge clk);
    reset_p  = 1'b0;
    no_check = 0;
    fd = 0;
    repeat (200) begin
      @(negedge clk);
      if (frame_done) fd++;
    end
    chk("abort_no_frame_done", fd, 0);
    chk("abort_no_frame", frames - f0, 0);
    data_flat = 32'h0000_005C;
    req       = 4'b1001;
    wait_ack(2'd0, 8'h5C, 1'b1);
    req = 4'b0;
    wait_idle(a);

    // A one-cycle request while busy must never be served.
    data_flat = 32'h0000_33A7;
    req       = 4'b0001;
    wait_ack(2'd0, 8'hA7, 1'b1);
    req = 4'b0;
    f0  = frames;
    repeat (20) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0;
    wait_idle(a);
    chk("busy_req_ack", a, 0);
    chk("busy_req_frames", frames - f0, 1);
    repeat (40) @(negedge clk);
    chk("busy_req_late", frames - f0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
